// File: rtl/branch_ctrl.sv
// branch_ctrl: resolves B/BR conditional branches against committed {N,V,Z}, interlocks on pending
// flag writes, and issues a registered redirect plus fixed-length flush. Macro BRANCH_STATS_EN adds counters.
module branch_ctrl #(
  parameter int PC_W      = 16,
  parameter int IMM_W     = 9,
  parameter int FLUSH_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  input  logic             br_is_reg,
  input  logic [2:0]       cond,
  input  logic [IMM_W-1:0] imm,
  input  logic [PC_W-1:0]  reg_target,
  input  logic [PC_W-1:0]  pc_plus2,
  input  logic [2:0]       flags,
  input  logic             flag_pend,
  output logic             stall,
  output logic             redirect,
  output logic             taken,
  output logic [PC_W-1:0]  pc_redirect,
  output logic             flush
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]      br_count,
  output logic [15:0]      taken_count
`endif
);

  // state | meaning
  // IDLE  | accept a branch from decode; resolve at once unless a flag write is pending
  // HOLD  | waiting for the older flag write to commit; stall held high
  // FLUSH | taken branch squashing wrong-path instructions for FLUSH_CYC cycles

  localparam int CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cond_q;
  logic [IMM_W-1:0]  imm_q;
  logic              is_reg_q;
  logic [PC_W-1:0]   reg_target_q, pc_plus2_q;
  logic              redirect_q, taken_q, flush_q;
  logic [PC_W-1:0]   pc_redirect_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [2:0]        r_cond;
  logic [IMM_W-1:0]  r_imm;
  logic              r_is_reg;
  logic [PC_W-1:0]   r_reg, r_pc, off_ext, target;
  logic              cond_ok, hazard, resolve, stall_c;

  always_comb begin
    // In IDLE the live operands are the ones being captured this cycle
    r_cond   = (state_q == S_IDLE) ? cond       : cond_q;
    r_imm    = (state_q == S_IDLE) ? imm        : imm_q;
    r_is_reg = (state_q == S_IDLE) ? br_is_reg  : is_reg_q;
    r_reg    = (state_q == S_IDLE) ? reg_target : reg_target_q;
    r_pc     = (state_q == S_IDLE) ? pc_plus2   : pc_plus2_q;

    case (r_cond)
      3'b000:  cond_ok = ~flags[0];
      3'b001:  cond_ok = flags[0];
      3'b010:  cond_ok = ~flags[0] & ~flags[2];
      3'b011:  cond_ok = flags[2];
      3'b100:  cond_ok = flags[0] | (~flags[0] & ~flags[2]);
      3'b101:  cond_ok = flags[2] | flags[0];
      3'b110:  cond_ok = flags[1];
      default: cond_ok = 1'b1;
    endcase

    off_ext = {{(PC_W-IMM_W){r_imm[IMM_W-1]}}, r_imm};
    if (!cond_ok)      target = r_pc;
    else if (r_is_reg) target = r_reg;
    else               target = r_pc + (off_ext << 1);

    hazard  = br_valid & flag_pend & (cond != 3'b111);
    resolve = 1'b0;
    stall_c = 1'b0;
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        stall_c = hazard;
        resolve = br_valid & ~hazard;
        if (hazard) state_d = S_HOLD;
      end
      S_HOLD: begin
        stall_c = 1'b1;
        resolve = ~flag_pend;
      end
      S_FLUSH: begin
        if (cnt_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (resolve) state_d = cond_ok ? S_FLUSH : S_IDLE;
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] br_count_q, taken_count_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cond_q        <= '0;
      imm_q         <= '0;
      is_reg_q      <= 1'b0;
      reg_target_q  <= '0;
      pc_plus2_q    <= '0;
      redirect_q    <= 1'b0;
      taken_q       <= 1'b0;
      flush_q       <= 1'b0;
      pc_redirect_q <= '0;
      cnt_q         <= '0;
`ifdef BRANCH_STATS_EN
      br_count_q    <= '0;
      taken_count_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      redirect_q <= resolve;
      flush_q    <= (state_d == S_FLUSH);
      if (state_q == S_IDLE && br_valid) begin
        cond_q       <= cond;
        imm_q        <= imm;
        is_reg_q     <= br_is_reg;
        reg_target_q <= reg_target;
        pc_plus2_q   <= pc_plus2;
      end
      if (resolve) begin
        taken_q       <= cond_ok;
        pc_redirect_q <= target;
      end
      if (resolve && cond_ok)
        cnt_q <= CNT_W'(FLUSH_CYC - 1);
      else if (state_q == S_FLUSH && cnt_q != '0)
        cnt_q <= cnt_q - CNT_W'(1);
`ifdef BRANCH_STATS_EN
      if (resolve && br_count_q != 16'hFFFF)
        br_count_q <= br_count_q + 16'd1;
      if (resolve && cond_ok && taken_count_q != 16'hFFFF)
        taken_count_q <= taken_count_q + 16'd1;
`endif
    end
  end

  assign stall       = stall_c & ~rst;
  assign redirect    = redirect_q;
  assign taken       = taken_q;
  assign pc_redirect = pc_redirect_q;
  assign flush       = flush_q;
`ifdef BRANCH_STATS_EN
  assign br_count    = br_count_q;
  assign taken_count = taken_count_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed plan scenarios plus randomized branches vs a behavioural model.
module tb_branch_ctrl;
  localparam int PC_W      = 16;
  localparam int IMM_W     = 9;
  localparam int FLUSH_CYC = 2;

  logic             clk = 1'b0;
  logic             rst, br_valid, br_is_reg, flag_pend;
  logic [2:0]       cond, flags;
  logic [IMM_W-1:0] imm;
  logic [PC_W-1:0]  reg_target, pc_plus2;
  logic             stall, redirect, taken, flush;
  logic [PC_W-1:0]  pc_redirect;
`ifdef BRANCH_STATS_EN
  logic [15:0]      br_count, taken_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_br   = 0;
  int exp_tk   = 0;

  always #5 clk = ~clk;

  branch_ctrl #(.PC_W(PC_W), .IMM_W(IMM_W), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_is_reg(br_is_reg), .cond(cond), .imm(imm),
    .reg_target(reg_target), .pc_plus2(pc_plus2), .flags(flags), .flag_pend(flag_pend),
    .stall(stall), .redirect(redirect), .taken(taken), .pc_redirect(pc_redirect), .flush(flush)
`ifdef BRANCH_STATS_EN
    , .br_count(br_count), .taken_count(taken_count)
`endif
  );

  // Reference: condition table from the flag meanings, target via integer arithmetic
  function automatic bit cond_m(int c, bit n, bit v, bit z);
    case (c)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || (!z && !n);
      5: return n || z;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [15:0] target_m(bit tk, bit is_reg, int imm_v, int regt, int pc);
    int off, t;
    if (!tk) return 16'(pc);
    if (is_reg) return 16'(regt);
    off = (imm_v >= 256) ? imm_v - 512 : imm_v;
    t = ((pc + 2 * off) % 65536 + 65536) % 65536;
    return 16'(t);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    br_valid = 0; br_is_reg = 0; cond = 0; imm = 0; reg_target = 0; pc_plus2 = 0; flag_pend = 0;
  endtask

  task automatic test_reset;
    rst = 1; idle_inputs(); flags = 0;
    tick(); tick();
    rst = 0; #1;
    n_checks++;
    if ({stall, redirect, taken, flush, pc_redirect} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b %b %b %b %h exp all zero", stall, redirect, taken, flush, pc_redirect);
    end
`ifdef BRANCH_STATS_EN
    n_checks++;
    if ({br_count, taken_count} !== 32'h0) begin
      n_fail++; $display("FAIL reset_counters: got %h %h exp 0", br_count, taken_count);
    end
`endif
    tick();
    n_checks++;
    if ({stall, redirect, flush} !== 3'b000) begin
      n_fail++; $display("FAIL idle_quiet: got stall=%b redirect=%b flush=%b exp 000", stall, redirect, flush);
    end
  endtask

  task automatic test_b_eq;
    br_valid = 1; br_is_reg = 0; cond = 3'b001; imm = 9'h004; pc_plus2 = 16'h0010; flags = 3'b001; flag_pend = 0;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL b_eq_stall: got %b exp 0", stall); end
    tick();
    exp_br++; exp_tk++;
    cond = 3'b111; br_is_reg = 1; reg_target = 16'h1234;
    #1;
    n_checks++;
    if ({redirect, taken, flush, stall, pc_redirect} !== {4'b1110, 16'h0018}) begin
      n_fail++;
      $display("FAIL b_eq_resolve: got r=%b t=%b f=%b s=%b pc=%h exp 1110 0018", redirect, taken, flush, stall, pc_redirect);
    end
    tick();
    n_checks++;
    if ({redirect, flush, stall} !== 3'b010) begin
      n_fail++; $display("FAIL b_eq_flush2: got r=%b f=%b s=%b exp 010", redirect, flush, stall);
    end
    br_valid = 0;
    tick();
    n_checks++;
    if ({redirect, flush, pc_redirect} !== {2'b00, 16'h0018}) begin
      n_fail++; $display("FAIL b_eq_end: got r=%b f=%b pc=%h exp 00 0018", redirect, flush, pc_redirect);
    end
  endtask

  task automatic test_hazard;
    int stalls = 0;
    br_valid = 1; br_is_reg = 0; cond = 3'b011; imm = 9'h010; pc_plus2 = 16'h0100; flags = 3'b000; flag_pend = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      stalls += (stall === 1'b1) ? 1 : 0;
      n_checks++;
      if (redirect !== 1'b0) begin n_fail++; $display("FAIL hazard_early_redirect: cycle %0d got %b exp 0", k, redirect); end
      tick();
      br_valid = 0; cond = 3'b000; imm = 9'h1FF;
      flag_pend = (k < 2);
      flags = (k < 2) ? 3'b000 : 3'b100;
    end
    #1;
    stalls += (stall === 1'b1) ? 1 : 0;
    exp_br++; exp_tk++;
    n_checks++;
    if (stalls !== 4) begin n_fail++; $display("FAIL hazard_stall_cycles: got %0d exp 4", stalls); end
    n_checks++;
    if ({redirect, taken, flush, pc_redirect} !== {3'b111, 16'h0120}) begin
      n_fail++; $display("FAIL hazard_resolve: got r=%b t=%b f=%b pc=%h exp 111 0120", redirect, taken, flush, pc_redirect);
    end
    tick(); tick();
  endtask

  task automatic test_not_taken_wrap;
    br_valid = 1; br_is_reg = 0; cond = 3'b000; imm = 9'h1F0; pc_plus2 = 16'h0002; flags = 3'b001; flag_pend = 0;
    tick();
    exp_br++;
    flags = 3'b000;
    #1;
    n_checks++;
    if ({redirect, taken, flush, pc_redirect} !== {3'b100, 16'h0002}) begin
      n_fail++; $display("FAIL nt_resolve: got r=%b t=%b f=%b pc=%h exp 100 0002", redirect, taken, flush, pc_redirect);
    end
    tick();
    exp_br++; exp_tk++;
    br_valid = 0;
    #1;
    n_checks++;
    if ({redirect, taken, flush, pc_redirect} !== {3'b111, 16'hFFE2}) begin
      n_fail++; $display("FAIL wrap_back_to_back: got r=%b t=%b f=%b pc=%h exp 111 ffe2", redirect, taken, flush, pc_redirect);
    end
    tick(); tick();
  endtask

  task automatic test_uncond_hazard;
    br_valid = 1; br_is_reg = 1; cond = 3'b111; reg_target = 16'hBEEF; pc_plus2 = 16'h0040;
    imm = 9'h003; flags = 3'($urandom); flag_pend = 1;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL uncond_stall: got %b exp 0", stall); end
    tick();
    exp_br++; exp_tk++;
    br_valid = 0; flag_pend = 0;
    #1;
    n_checks++;
    if ({redirect, taken, pc_redirect} !== {2'b11, 16'hBEEF}) begin
      n_fail++; $display("FAIL uncond_resolve: got r=%b t=%b pc=%h exp 11 beef", redirect, taken, pc_redirect);
    end
    tick(); tick();
  endtask

  task automatic test_random;
    int c, imm_v, regt, pc, h;
    bit rreg, tk, hz;
    logic [2:0] fl;
    logic [15:0] exp_pc;
    for (int it = 0; it < 60; it++) begin
      c = $urandom_range(0, 7); imm_v = $urandom_range(0, 511); regt = $urandom_range(0, 65535);
      pc = $urandom_range(0, 65535); rreg = 1'($urandom); h = $urandom_range(0, 3);
      fl = 3'($urandom);
      hz = (h > 0) && (c != 7);
      br_valid = 1; cond = 3'(c); imm = 9'(imm_v); reg_target = 16'(regt); pc_plus2 = 16'(pc);
      br_is_reg = rreg; flags = fl; flag_pend = (h > 0);
      #1;
      n_checks++;
      if (stall !== hz) begin n_fail++; $display("FAIL rand_stall0: iter %0d got %b exp %b", it, stall, hz); end
      if (hz) begin
        for (int k = 1; k <= h; k++) begin
          tick();
          br_valid = 1'($urandom); cond = 3'($urandom); imm = 9'($urandom); reg_target = 16'($urandom);
          pc_plus2 = 16'($urandom); br_is_reg = 1'($urandom); fl = 3'($urandom); flags = fl;
          flag_pend = (k < h);
          #1;
          n_checks++;
          if ({stall, redirect} !== 2'b10) begin
            n_fail++; $display("FAIL rand_hold: iter %0d cycle %0d got s=%b r=%b exp 10", it, k, stall, redirect);
          end
        end
      end
      tk = cond_m(c, fl[2], fl[1], fl[0]);
      exp_pc = target_m(tk, rreg, imm_v, regt, pc);
      tick();
      exp_br++; exp_tk += tk ? 1 : 0;
      idle_inputs();
      #1;
      n_checks++;
      if ({redirect, taken, flush, stall, pc_redirect} !== {1'b1, tk, tk, 1'b0, exp_pc}) begin
        n_fail++;
        $display("FAIL rand_resolve: iter %0d got r=%b t=%b f=%b s=%b pc=%h exp 1 %b %b 0 %h",
                 it, redirect, taken, flush, stall, pc_redirect, tk, tk, exp_pc);
      end
      if (tk) begin
        for (int j = 2; j <= FLUSH_CYC; j++) begin
          tick();
          br_valid = 1'($urandom); flag_pend = 1'($urandom); cond = 3'($urandom);
          #1;
          n_checks++;
          if ({redirect, flush, stall} !== 3'b010) begin
            n_fail++; $display("FAIL rand_flush: iter %0d cycle %0d got r=%b f=%b s=%b exp 010", it, j, redirect, flush, stall);
          end
        end
      end
      tick();
      idle_inputs();
      #1;
      n_checks++;
      if ({redirect, flush} !== 2'b00) begin
        n_fail++; $display("FAIL rand_settle: iter %0d got r=%b f=%b exp 00", it, redirect, flush);
      end
    end
`ifdef BRANCH_STATS_EN
    n_checks++;
    if (br_count !== 16'(exp_br) || taken_count !== 16'(exp_tk)) begin
      n_fail++; $display("FAIL stats_counts: got %0d %0d exp %0d %0d", br_count, taken_count, exp_br, exp_tk);
    end
`endif
  endtask

  task automatic test_reset_in_hold;
    br_valid = 1; br_is_reg = 0; cond = 3'b001; imm = 9'h002; pc_plus2 = 16'h0200; flags = 3'b001; flag_pend = 1;
    tick();
    br_valid = 0;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL hold_entry: got stall=%b exp 1", stall); end
    rst = 1;
    tick();
    rst = 0; exp_br = 0; exp_tk = 0;
    #1;
    n_checks++;
    if ({stall, redirect, flush} !== 3'b000) begin
      n_fail++; $display("FAIL rst_hold_exit: got s=%b r=%b f=%b exp 000", stall, redirect, flush);
    end
    flag_pend = 0;
    tick();
    n_checks++;
    if ({stall, redirect, flush} !== 3'b000) begin
      n_fail++; $display("FAIL rst_hold_no_resolve: got s=%b r=%b f=%b exp 000", stall, redirect, flush);
    end
`ifdef BRANCH_STATS_EN
    n_checks++;
    if ({br_count, taken_count} !== 32'h0) begin
      n_fail++; $display("FAIL rst_hold_counters: got %h %h exp 0", br_count, taken_count);
    end
`endif
    br_valid = 1; cond = 3'b111; br_is_reg = 1; reg_target = 16'h0ABC;
    tick();
    br_valid = 0;
    #1;
    n_checks++;
    if (flush !== 1'b1) begin n_fail++; $display("FAIL rst_flush_setup: got flush=%b exp 1", flush); end
    rst = 1;
    tick();
    rst = 0;
    #1;
    n_checks++;
    if ({flush, redirect, stall} !== 3'b000) begin
      n_fail++; $display("FAIL rst_flush_exit: got f=%b r=%b s=%b exp 000", flush, redirect, stall);
    end
  endtask

  initial begin
    test_reset();
    test_b_eq();
    test_hazard();
    test_not_taken_wrap();
    test_uncond_hazard();
    test_random();
    test_reset_in_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Downstream consumer of the flag register's {N,V,Z} outputs.
- Resolves conditional branches (B: PC-relative immediate; BR: register target) against the committed flags.
- Interlocks against a pending flag write from an older in-flight instruction.
- Issues a registered PC redirect and a fixed-length pipeline flush on taken branches.

Parameters:
- PC_W, 16, PC/target width.
- IMM_W, 9, branch immediate width in halfwords, signed.
- FLUSH_CYC, 2, cycles flush is held after a taken branch (>=1).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- br_valid  in  1  branch instruction present in decode this cycle.
- br_is_reg  in  1  1 = BR (target = reg_target), 0 = B (PC-relative).
- cond  in  3  condition code (encoding below).
- imm  in  IMM_W  signed halfword offset.
- reg_target  in  PC_W  register-sourced target.
- pc_plus2  in  PC_W  address of the instruction after the branch.
- flags  in  3  {N,V,Z}, committed flag register outputs.
- flag_pend  in  1  an older instruction will write flags but has not committed.
- stall  out  1  hold fetch/decode; combinational.
- redirect  out  1  one-cycle pulse; pc_redirect valid; registered.
- taken  out  1  resolved branch was taken; registered, valid with redirect.
- pc_redirect  out  PC_W  next fetch address; registered.
- flush  out  1  squash younger instructions; registered.

Behaviour:
- Reset: state=IDLE, stall=0, redirect=0, taken=0, flush=0, pc_redirect=0, flush counter=0, captured operands=0.
- Condition codes:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 & N=0
  - 011 LT: N=1
  - 100 GE: Z=1 | (Z=0 & N=0)
  - 101 LE: N=1 | Z=1
  - 110 OV: V=1
  - 111 UNCOND: always taken
- Target:
  - B: pc_plus2 + (sign_extend(imm) << 1), truncated mod 2^PC_W (wrap-around allowed, no fault).
  - BR: reg_target.
  - Not taken: pc_plus2.
- Operand capture: on every accepted br_valid in IDLE, cond/imm/br_is_reg/reg_target/pc_plus2 are registered. Resolution always uses the captured copy.
- States:
  - IDLE:
    - br_valid=0: nothing happens.
    - br_valid=1 & (cond=111 | flag_pend=0): resolve this cycle (cycle R).
    - br_valid=1 & flag_pend=1 & cond!=111: stall=1 combinationally, next state HOLD.
  - HOLD:
    - stall=1 every cycle, including the exit cycle.
    - br_valid is ignored (upstream is held).
    - flag_pend=1: remain in HOLD.
    - flag_pend=0: resolve using the current flags (already updated by the committed write), next state IDLE or FLUSH.
  - FLUSH:
    - flush=1 for exactly FLUSH_CYC consecutive cycles, starting R+1.
    - br_valid is ignored (wrong-path); stall=0.
    - Returns to IDLE after the last flush cycle.
- Resolve in cycle R:
  - At the R edge, register taken and pc_redirect.
  - redirect=1 in cycle R+1 only (both taken and not-taken).
  - Taken: next state FLUSH.
  - Not taken: flush stays 0, next state IDLE; a new br_valid may be accepted in cycle R+1.
- Latency: 1 cycle from resolution to redirect. Stall cycles = number of HOLD cycles + 1.
- Simultaneous events: flag_pend falling in the same cycle br_valid arrives in IDLE means no hazard; resolve immediately.
- Reset mid-HOLD or mid-FLUSH: return to IDLE next cycle; no redirect; flush drops immediately.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - Adds outputs br_count[15:0] and taken_count[15:0], both saturating at 16'hFFFF and cleared by rst.
  - Each resolution increments br_count; each taken resolution also increments taken_count.
  - Counters update at the R edge.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> all outputs 0; stall=0 with br_valid=0.
- B EQ, no hazard: pc_plus2=16'h0010, imm=9'h004, flags=001, cond=001, br_valid=1 -> cycle R+1: redirect=1, taken=1, pc_redirect=16'h0018; flush=1 for 2 cycles; br_valid during flush is ignored.
- Flag hazard: cond=011 with flag_pend=1 for 3 cycles while the flag register goes to N=1 -> stall=1 for 4 cycles total; resolves taken using the new N; redirect the following cycle.
- Not taken with negative offset and wrap: pc_plus2=16'h0002, imm=9'h1F0, cond=000, Z=1 -> taken=0, pc_redirect=16'h0002, flush never asserted. Same stimulus with Z=0 -> pc_redirect=16'hFFE2.
- BR unconditional during hazard: cond=111, br_is_reg=1, reg_target=16'hBEEF, flag_pend=1 -> no stall, pc_redirect=16'hBEEF next cycle.
- Reset in HOLD: rst pulsed while stalled -> next cycle IDLE, stall=0, no redirect. With BRANCH_STATS_EN: counters read 0.
